// File: rtl/frontend_arbiter.sv
// Packet-granular round-robin arbiter feeding the shared decompression frontend.
// Optional port-0 priority is selected with `define FRONTEND_ARB_PORT0_PRIO_EN.
module frontend_arbiter #(
   parameter int NUM_PORTS = 4,
   parameter int IDW       = 2,
   parameter int MAX_BEATS = 48
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic [NUM_PORTS*256-1:0] s_tdata,
   input  logic [NUM_PORTS*32-1:0]  s_tkeep,
   input  logic [NUM_PORTS-1:0]     s_tvalid,
   input  logic [NUM_PORTS-1:0]     s_tlast,
   output logic [NUM_PORTS-1:0]     s_tready,
   output logic [255:0]             m_tdata,
   output logic [31:0]              m_tkeep,
   output logic                     m_tvalid,
   output logic                     m_tlast,
   output logic [IDW-1:0]           m_tid,
   input  logic                     m_tready,
   output logic                     busy,
   output logic                     err_oversize
);

`ifdef FRONTEND_ARB_PORT0_PRIO_EN
   localparam bit PRIO_EN = 1'b1;
`else
   localparam bit PRIO_EN = 1'b0;
`endif

   localparam logic [6:0] MAX_B = 7'(MAX_BEATS);

   typedef enum logic {ARB, XFER} state_t;

   state_t         state_reg;
   logic [IDW-1:0] grant_reg;
   logic [IDW-1:0] last_grant_reg;
   logic [6:0]     beat_cnt_reg;
   logic           err_reg;

   logic [1:0]     fifo_count_reg;
   logic           wr_ptr_reg;
   logic           rd_ptr_reg;
   logic [255:0]   fifo_data_reg [2];
   logic [31:0]    fifo_keep_reg [2];
   logic           fifo_last_reg [2];
   logic [IDW-1:0] fifo_id_reg   [2];

   logic [IDW-1:0] pick;
   logic [IDW-1:0] cand;
   logic           pick_valid;
   logic           fifo_room;
   logic           accept;
   logic           pop;
   logic           in_last;
   logic [255:0]   in_data;
   logic [31:0]    in_keep;
   logic [6:0]     beat_cnt_next;

   function automatic logic [IDW-1:0] port_at(input logic [IDW-1:0] base, input int offset);
      int idx;
      idx = (int'(base) + offset) % NUM_PORTS;
      return IDW'(idx);
   endfunction

   // Rotating scan starting just after the previous winner; port 0 is pulled out
   // of the rotation when it has fixed priority.
   always_comb begin
      pick       = '0;
      cand       = '0;
      pick_valid = 1'b0;
      if (PRIO_EN && s_tvalid[0]) begin
         pick_valid = 1'b1;
      end else begin
         for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = port_at(last_grant_reg, i);
            if (!pick_valid && s_tvalid[cand] && !(PRIO_EN && cand == '0)) begin
               pick       = cand;
               pick_valid = 1'b1;
            end
         end
      end
   end

   // Ready looks only at the registered count: no credit for a same-cycle pop.
   assign fifo_room = (fifo_count_reg != 2'd2);
   assign accept    = (state_reg == XFER) && s_tvalid[grant_reg] && fifo_room;
   assign pop       = (fifo_count_reg != 2'd0) && m_tready;
   assign in_last   = s_tlast[grant_reg];
   assign in_data   = s_tdata[int'(grant_reg)*256 +: 256];
   assign in_keep   = s_tkeep[int'(grant_reg)*32 +: 32];
   assign beat_cnt_next = (beat_cnt_reg == 7'd127) ? 7'd127 : beat_cnt_reg + 7'd1;

   always_comb begin
      s_tready = '0;
      if (state_reg == XFER && fifo_room)
         s_tready[grant_reg] = 1'b1;
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_reg      <= ARB;
         grant_reg      <= '0;
         last_grant_reg <= IDW'(NUM_PORTS - 1);
         beat_cnt_reg   <= '0;
         err_reg        <= 1'b0;
         fifo_count_reg <= '0;
         wr_ptr_reg     <= 1'b0;
         rd_ptr_reg     <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            fifo_data_reg[i] <= '0;
            fifo_keep_reg[i] <= '0;
            fifo_last_reg[i] <= 1'b0;
            fifo_id_reg[i]   <= '0;
         end
      end else begin
         case (state_reg)
            ARB: begin
               if (pick_valid) begin
                  grant_reg    <= pick;
                  beat_cnt_reg <= '0;
                  state_reg    <= XFER;
               end
            end
            XFER: begin
               if (accept) begin
                  beat_cnt_reg <= beat_cnt_next;
                  if (beat_cnt_next > MAX_B)
                     err_reg <= 1'b1;
                  if (in_last) begin
                     state_reg <= ARB;
                     if (!PRIO_EN || grant_reg != '0)
                        last_grant_reg <= grant_reg;
                  end
               end
            end
            default: state_reg <= ARB;
         endcase

         if (accept) begin
            fifo_data_reg[wr_ptr_reg] <= in_data;
            fifo_keep_reg[wr_ptr_reg] <= in_keep;
            fifo_last_reg[wr_ptr_reg] <= in_last;
            fifo_id_reg[wr_ptr_reg]   <= grant_reg;
            wr_ptr_reg                <= ~wr_ptr_reg;
         end
         if (pop)
            rd_ptr_reg <= ~rd_ptr_reg;
         if (accept && !pop)
            fifo_count_reg <= fifo_count_reg + 2'd1;
         else if (!accept && pop)
            fifo_count_reg <= fifo_count_reg - 2'd1;
      end
   end

   assign m_tvalid     = (fifo_count_reg != 2'd0);
   assign m_tdata      = fifo_data_reg[rd_ptr_reg];
   assign m_tkeep      = fifo_keep_reg[rd_ptr_reg];
   assign m_tlast      = fifo_last_reg[rd_ptr_reg];
   assign m_tid        = fifo_id_reg[rd_ptr_reg];
   assign busy         = (state_reg == XFER);
   assign err_oversize = err_reg;

endmodule
